// File: rtl/vscale_htif_tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vscale_htif_tohost_monitor
// Brief    : HTIF PCR host agent that polls tohost and reports pass/fail/timeout.
//            Optional tohost clear-after-read: VSCALE_HTIF_TOHOST_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vscale_htif_tohost_monitor #(
  parameter int                    PCR_WIDTH   = 64,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 12'h780,
  parameter int                    CYCLE_WIDTH = 32,
  parameter int                    POLL_GAP    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CYCLE_WIDTH-1:0] max_cycles,
  output logic                   htif_pcr_req_valid,
  input  logic                   htif_pcr_req_ready,
  output logic                   htif_pcr_req_rw,
  output logic [ADDR_WIDTH-1:0]  htif_pcr_req_addr,
  output logic [PCR_WIDTH-1:0]   htif_pcr_req_data,
  input  logic                   htif_pcr_resp_valid,
  output logic                   htif_pcr_resp_ready,
  input  logic [PCR_WIDTH-1:0]   htif_pcr_resp_data,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [PCR_WIDTH-2:0]   fail_code,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);

  localparam int                 GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(POLL_GAP - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_RESP     = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
`ifdef VSCALE_HTIF_TOHOST_CLEAR_EN
  localparam logic [2:0] S_CLR_REQ  = 3'd4;
  localparam logic [2:0] S_CLR_RESP = 3'd5;
`endif
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]             r_state;
  logic [2:0]             w_next_state;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic [CYCLE_WIDTH-1:0] r_cycle_count;
  logic                   r_pass;
  logic                   r_timeout;
  logic [PCR_WIDTH-2:0]   r_fail_code;

  logic                   w_active;
  logic                   w_timeout;
  logic                   w_req_hs;
  logic                   w_resp_hs;
  logic                   w_resp_nz;
  logic                   w_finish_result;
  logic                   w_finish_timeout;
  logic [PCR_WIDTH-1:0]   w_result;

`ifdef VSCALE_HTIF_TOHOST_CLEAR_EN
  logic [PCR_WIDTH-1:0]   r_data;
`endif

  assign w_active  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_timeout = (max_cycles != '0) && (r_cycle_count >= max_cycles) && w_active;
  assign w_req_hs  = htif_pcr_req_valid && htif_pcr_req_ready;
  assign w_resp_hs = htif_pcr_resp_valid && htif_pcr_resp_ready;
  assign w_resp_nz = (htif_pcr_resp_data != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a nonzero response handshake outranks a same-cycle timeout
  always_comb begin
    w_next_state     = r_state;
    w_finish_result  = 1'b0;
    w_finish_timeout = 1'b0;
`ifdef VSCALE_HTIF_TOHOST_CLEAR_EN
    w_result         = r_data;
`else
    w_result         = htif_pcr_resp_data;
`endif
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (w_timeout) begin
          w_next_state     = S_DONE;
          w_finish_timeout = 1'b1;
        end else if (w_req_hs) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (w_resp_hs && w_resp_nz) begin
`ifdef VSCALE_HTIF_TOHOST_CLEAR_EN
          w_next_state = S_CLR_REQ;
`else
          w_next_state    = S_DONE;
          w_finish_result = 1'b1;
`endif
        end else if (w_timeout) begin
          w_next_state     = S_DONE;
          w_finish_timeout = 1'b1;
        end else if (w_resp_hs) begin
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (w_timeout) begin
          w_next_state     = S_DONE;
          w_finish_timeout = 1'b1;
        end else if (!enable) begin
          w_next_state = S_IDLE;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_next_state = S_REQ;
        end
      end
`ifdef VSCALE_HTIF_TOHOST_CLEAR_EN
      S_CLR_REQ: begin
        if (w_timeout) begin
          w_next_state     = S_DONE;
          w_finish_timeout = 1'b1;
        end else if (w_req_hs) begin
          w_next_state = S_CLR_RESP;
        end
      end
      S_CLR_RESP: begin
        if (w_resp_hs) begin
          w_next_state    = S_DONE;
          w_finish_result = 1'b1;
        end else if (w_timeout) begin
          w_next_state     = S_DONE;
          w_finish_timeout = 1'b1;
        end
      end
`endif
      S_DONE: begin
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    htif_pcr_req_valid  = 1'b0;
    htif_pcr_req_rw     = 1'b0;
    htif_pcr_resp_ready = 1'b0;
    done                = 1'b0;
    case (r_state)
      S_REQ: begin
        htif_pcr_req_valid = 1'b1;
      end
      S_RESP: begin
        htif_pcr_resp_ready = 1'b1;
      end
`ifdef VSCALE_HTIF_TOHOST_CLEAR_EN
      S_CLR_REQ: begin
        htif_pcr_req_valid = 1'b1;
        htif_pcr_req_rw    = 1'b1;
      end
      S_CLR_RESP: begin
        htif_pcr_resp_ready = 1'b1;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign htif_pcr_req_addr = TOHOST_ADDR;
  assign htif_pcr_req_data = '0;

  // Idle spacing between polls; restarts from zero on every entry to GAP
  always_ff @(posedge clk) begin
    if (!reset || (r_state != S_GAP)) begin
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_count <= '0;
    end else if (w_active && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

`ifdef VSCALE_HTIF_TOHOST_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
    end else if ((r_state == S_RESP) && w_resp_hs) begin
      r_data <= htif_pcr_resp_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_code <= '0;
    end else if (w_finish_timeout) begin
      r_pass      <= 1'b0;
      r_timeout   <= 1'b1;
      r_fail_code <= '0;
    end else if (w_finish_result) begin
      r_pass      <= (w_result == PCR_WIDTH'(1));
      r_timeout   <= 1'b0;
      r_fail_code <= (w_result == PCR_WIDTH'(1)) ? '0 : w_result[PCR_WIDTH-1:1];
    end
  end

  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign fail_code   = r_fail_code;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_vscale_htif_tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vscale_htif_tohost_monitor
// Brief    : Directed bench for the tohost monitor with a small HTIF core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vscale_htif_tohost_monitor;

`ifdef VSCALE_HTIF_TOHOST_CLEAR_EN
  localparam bit CLR_BUILD = 1'b1;
`else
  localparam bit CLR_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] max_cycles = '0;
  logic        htif_pcr_req_valid;
  logic        htif_pcr_req_ready = 1'b0;
  logic        htif_pcr_req_rw;
  logic [11:0] htif_pcr_req_addr;
  logic [63:0] htif_pcr_req_data;
  logic        htif_pcr_resp_valid = 1'b0;
  logic        htif_pcr_resp_ready;
  logic [63:0] htif_pcr_resp_data = '0;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [62:0] fail_code;
  logic [31:0] cycle_count;

  vscale_htif_tohost_monitor dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .max_cycles          (max_cycles),
    .htif_pcr_req_valid  (htif_pcr_req_valid),
    .htif_pcr_req_ready  (htif_pcr_req_ready),
    .htif_pcr_req_rw     (htif_pcr_req_rw),
    .htif_pcr_req_addr   (htif_pcr_req_addr),
    .htif_pcr_req_data   (htif_pcr_req_data),
    .htif_pcr_resp_valid (htif_pcr_resp_valid),
    .htif_pcr_resp_ready (htif_pcr_resp_ready),
    .htif_pcr_resp_data  (htif_pcr_resp_data),
    .done                (done),
    .pass                (pass),
    .timeout             (timeout),
    .fail_code           (fail_code),
    .cycle_count         (cycle_count)
  );

  initial forever #5 clk = ~clk;

  // Core model configuration (written only by the main sequence)
  int          cfg_zeros = 0;
  logic [63:0] cfg_final = 64'd1;
  int          cfg_stall = 0;
  int          cfg_lat   = 0;
  logic        flush     = 1'b1;

  // Core model state and observations (written only by the model)
  int          zeros_left = 0;
  logic        pending = 1'b0;
  logic        pend_rw = 1'b0;
  int          lat_cnt = 0;
  int          stall_cnt = 0;
  int          stall_bad = 0;
  int          bad_req = 0;
  int          reads = 0;
  int          writes = 0;
  int          gap_run = 0;
  int          gap_min = 1000;
  int          gap_max = 0;
  logic        snap_rw = 1'b0;
  logic [11:0] snap_addr = '0;
  logic [63:0] snap_data = '0;

  // Core model: acts 1 time unit after each falling edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (flush) begin
        pending = 1'b0; lat_cnt = 0; stall_cnt = 0; stall_bad = 0; bad_req = 0;
        reads = 0; writes = 0; gap_run = 0; gap_min = 1000; gap_max = 0;
        zeros_left = cfg_zeros;
        htif_pcr_req_ready = 1'b0; htif_pcr_resp_valid = 1'b0; htif_pcr_resp_data = '0;
      end else begin
        htif_pcr_resp_valid = 1'b0;
        if (pending) begin
          if (lat_cnt > 0) begin
            lat_cnt--;
          end else begin
            htif_pcr_resp_valid = 1'b1;
            htif_pcr_resp_data  = pend_rw ? 64'hDEAD_BEEF : ((zeros_left > 0) ? 64'd0 : cfg_final);
            if (htif_pcr_resp_ready && reset) begin
              pending = 1'b0;
              if (!pend_rw && zeros_left > 0) zeros_left--;
            end
          end
        end
        htif_pcr_req_ready = 1'b0;
        if (htif_pcr_req_valid) begin
          if (stall_cnt > 0 && (htif_pcr_req_rw !== snap_rw || htif_pcr_req_addr !== snap_addr ||
                                htif_pcr_req_data !== snap_data))
            stall_bad++;
          if (stall_cnt == 0) begin
            snap_rw = htif_pcr_req_rw; snap_addr = htif_pcr_req_addr; snap_data = htif_pcr_req_data;
          end
          if (stall_cnt < cfg_stall) begin
            stall_cnt++;
          end else begin
            htif_pcr_req_ready = 1'b1;
            if (reset) begin
              if (pending) stall_bad++;
              pending = 1'b1; pend_rw = htif_pcr_req_rw; lat_cnt = cfg_lat; stall_cnt = 0;
              if (htif_pcr_req_addr !== 12'h780 || htif_pcr_req_data !== 64'd0) bad_req++;
              if (htif_pcr_req_rw) begin
                writes++;
              end else begin
                if (reads > 0) begin
                  if (gap_run < gap_min) gap_min = gap_run;
                  if (gap_run > gap_max) gap_max = gap_run;
                end
                reads++;
              end
              gap_run = 0;
            end
          end
        end else begin
          if (stall_cnt > 0) stall_bad++;
          if (!htif_pcr_resp_ready && !done) gap_run++;
        end
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    int cyc;
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    int          zeros;
    logic [63:0] final_val;
    int          stall;
    int          lat;
    logic [31:0] maxc;
    logic        e_pass;
    logic        e_timeout;
    logic [62:0] e_fail;
    int          e_reads;
    int          e_writes;
    logic [31:0] e_count;
    bit          clr_to;
  } vec_t;

  localparam int NV = 8;
  vec_t vt[NV];

  function automatic vec_t mk(int zeros, logic [63:0] fv, int stall, int lat, logic [31:0] maxc,
                              logic ep, logic et, logic [62:0] ef, int er, logic [31:0] ec, bit clr_to);
    vec_t v;
    v.zeros = zeros; v.final_val = fv; v.stall = stall; v.lat = lat; v.maxc = maxc;
    v.e_pass = ep; v.e_timeout = et; v.e_fail = ef; v.e_reads = er; v.e_writes = 0;
    v.e_count = ec; v.clr_to = clr_to;
    return v;
  endfunction

  task automatic start_run(input int zeros, input logic [63:0] fv, input int stall, input int lat,
                           input logic [31:0] maxc);
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; max_cycles = maxc;
    cfg_zeros = zeros; cfg_final = fv; cfg_stall = stall; cfg_lat = lat; flush = 1'b1;
    repeat (3) @(negedge clk);
    flush = 1'b0; reset = 1'b1;
  endtask

  initial begin
    vec_t v;
    //        zeros   final  stall lat maxc  pass to fail reads count clr_to
    vt[0] = mk(3,      64'd1,  0,   0, 0,    1,   0, 0,   4,    20,   0);
    vt[1] = mk(0,      64'd21, 0,   0, 0,    0,   0, 10,  1,    2,    0);
    vt[2] = mk(0,      64'd1,  5,   0, 0,    1,   0, 0,   1,    7,    0);
    vt[3] = mk(1,      64'd1,  0,   3, 0,    1,   0, 0,   2,    14,   0);
    vt[4] = mk(2,      64'd7,  0,   0, 100,  0,   0, 3,   3,    14,   0);
    vt[5] = mk(100000, 64'd1,  0,   0, 50,   0,   1, 0,   9,    51,   0);
    vt[6] = mk(0,      64'd1,  49,  0, 50,   1,   0, 0,   1,    51,   1);
    vt[7] = mk(0,      64'd3,  0,   0, 0,    0,   0, 1,   1,    2,    0);

    // Reset held low with enable high, then first request
    reset = 1'b0; enable = 1'b1; flush = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_valid", htif_pcr_req_valid, 0);
    check("rst_req_rw", htif_pcr_req_rw, 0);
    check("rst_req_data", htif_pcr_req_data, 0);
    check("rst_resp_ready", htif_pcr_resp_ready, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_fail_code", fail_code, 0);
    check("rst_cycle_count", cycle_count, 0);
    flush = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("first_req_valid", htif_pcr_req_valid, 1);
    check("first_req_addr", htif_pcr_req_addr, 64'h780);
    check("first_req_rw", htif_pcr_req_rw, 0);
    wait_done(200);
    check("first_done", done, 1);

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      if (CLR_BUILD) begin
        if (v.clr_to) begin
          v.e_pass = 0; v.e_timeout = 1; v.e_fail = 0; v.e_count = 52;
        end else if (!v.e_timeout) begin
          v.e_count = v.e_count + 2; v.e_writes = 1;
        end
      end
      start_run(v.zeros, v.final_val, v.stall, v.lat, v.maxc);
      wait_done(2000);
      check($sformatf("v%0d_done", i), done, 1);
      check($sformatf("v%0d_pass", i), pass, v.e_pass);
      check($sformatf("v%0d_timeout", i), timeout, v.e_timeout);
      check($sformatf("v%0d_fail_code", i), fail_code, v.e_fail);
      check($sformatf("v%0d_reads", i), reads, v.e_reads);
      check($sformatf("v%0d_writes", i), writes, v.e_writes);
      check($sformatf("v%0d_cycle_count", i), cycle_count, v.e_count);
      check($sformatf("v%0d_stall_stable", i), stall_bad, 0);
      check($sformatf("v%0d_req_fields", i), bad_req, 0);
      if (i == 0) begin
        check("poll_gap_min", gap_min, 4);
        check("poll_gap_max", gap_max, 4);
      end
      // DONE is absorbing even with enable dropped
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_done_sticky", i), done, 1);
    end

    // Reset during RESP with a late nonzero response that must be ignored
    start_run(0, 64'd5, 0, 10, 0);
    begin
      int cyc;
      cyc = 0;
      while (!htif_pcr_resp_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("rr_in_resp", htif_pcr_resp_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_req_valid", htif_pcr_req_valid, 0);
    check("rr_resp_ready", htif_pcr_resp_ready, 0);
    check("rr_cycle_count", cycle_count, 0);
    check("rr_done", done, 0);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("rr_late_ignored_done", done, 0);
    check("rr_late_ignored_count", cycle_count, 0);
    cfg_zeros = 0; cfg_final = 64'd1; cfg_lat = 0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; enable = 1'b1;
    wait_done(200);
    check("rr_restart_done", done, 1);
    check("rr_restart_pass", pass, 1);
    check("rr_restart_reads", reads, 1);
    check("rr_restart_count", cycle_count, CLR_BUILD ? 4 : 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
